// File: rtl/wb_scoreboard.sv
// Write-back scoreboard: tracks in-flight register writers between ID/EX issue and
// MEM_WB retirement, and stalls ID when a source operand cannot be forwarded yet.
module wb_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [TOT_W-1:0] outstanding,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0]    cnt_r     [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt_s [NUM_REGS];
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] inc_s;
    logic [CNT_W-1:0]    eff_rs1_s;
    logic [CNT_W-1:0]    eff_rs2_s;
    logic [CNT_W-1:0]    eff_rd_s;
    logic                haz1_s;
    logic                haz2_s;
    logic                sat_s;
    logic                stall_s;
    logic                fire_s;
    logic                any_inc_s;
    logic                any_dec_s;
    logic                underflow_s;
    logic [TOT_W-1:0]    outstanding_r;
    logic [TOT_W-1:0]    outstanding_nxt_s;
    logic                err_r;

    // Retire strobes: only registers with a pending writer can be decremented
    always_comb begin
        dec_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            dec_s[r] = wb_regwrite && (wb_rd == 5'(r)) && (cnt_r[r] != CNT_ZERO);
        end
    end

    // Hazard decision: a same-cycle write-back is forwarded, so it counts as resolved
    always_comb begin
        eff_rs1_s   = cnt_r[id_rs1] - CNT_W'(dec_s[id_rs1]);
        eff_rs2_s   = cnt_r[id_rs2] - CNT_W'(dec_s[id_rs2]);
        eff_rd_s    = cnt_r[id_rd]  - CNT_W'(dec_s[id_rd]);
        haz1_s      = id_use_rs1 && (id_rs1 != 5'd0) && (eff_rs1_s != CNT_ZERO);
        haz2_s      = id_use_rs2 && (id_rs2 != 5'd0) && (eff_rs2_s != CNT_ZERO);
        sat_s       = id_regwrite && (id_rd != 5'd0) && (eff_rd_s == CNT_MAX);
        stall_s     = id_valid && (haz1_s || haz2_s || sat_s);
        fire_s      = id_valid && !stall_s;
        any_inc_s   = fire_s && id_regwrite && (id_rd != 5'd0);
        any_dec_s   = wb_regwrite && (wb_rd != 5'd0) && (cnt_r[wb_rd] != CNT_ZERO);
        underflow_s = wb_regwrite && (wb_rd != 5'd0) && (cnt_r[wb_rd] == CNT_ZERO);
    end

    // Issue strobes for the destination of the instruction leaving ID
    always_comb begin
        inc_s = {NUM_REGS{1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_s[r] = fire_s && id_regwrite && (id_rd == 5'(r));
        end
    end

    // Next counter values; flush squashes everything including this cycle's events
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
                cnt_nxt_s[r] = CNT_ZERO;
            end else begin
                cnt_nxt_s[r] = cnt_r[r] + CNT_W'(inc_s[r]) - CNT_W'(dec_s[r]);
            end
        end
        if (flush) begin
            outstanding_nxt_s = {TOT_W{1'b0}};
        end else begin
            outstanding_nxt_s = outstanding_r + TOT_W'(any_inc_s) - TOT_W'(any_dec_s);
        end
    end

    // Pending-writer counters and running total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            outstanding_r <= {TOT_W{1'b0}};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            outstanding_r <= outstanding_nxt_s;
        end
    end

    // Sticky underflow flag; survives flush, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (underflow_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign stall         = stall_s;
    assign issue_fire    = fire_s;
    assign outstanding   = outstanding_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_wb_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = 5'd0;
    logic [4:0] id_rs2 = 5'd0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] id_rd = 5'd0;
    logic       id_regwrite = 1'b0;
    logic [4:0] wb_rd = 5'd0;
    logic       wb_regwrite = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic       issue_fire;
    logic [6:0] outstanding;
    logic       err_underflow;

    typedef struct {
        logic       stall;
        logic       fire;
        logic [6:0] outs;
        logic       err;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    wb_scoreboard #(.NUM_REGS(32), .CNT_W(2), .TOT_W(7)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .flush(flush), .stall(stall), .issue_fire(issue_fire),
        .outstanding(outstanding), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string field, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", nm, field, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one expected entry is consumed per negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cmp(e.name, "stall", int'(stall), int'(e.stall));
                cmp(e.name, "issue_fire", int'(issue_fire), int'(e.fire));
                cmp(e.name, "outstanding", int'(outstanding), int'(e.outs));
                cmp(e.name, "err_underflow", int'(err_underflow), int'(e.err));
            end
        end
    end

    // Drive one cycle of inputs just after the edge and queue the expected outputs
    task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic [4:0] wrd, input logic ww,
                        input logic fl, input logic r,
                        input logic es, input logic ef, input logic [6:0] eo,
                        input logic ee, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
        id_use_rs2 = u2; id_rd = rd; id_regwrite = rw; wb_rd = wrd;
        wb_regwrite = ww; flush = fl;
        e.stall = es; e.fire = ef; e.outs = eo; e.err = ee; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        //    v  rs1 u1 rs2 u2 rd rw wrd ww fl rst  stall fire out err
        step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 1,   0, 1, 0, 0, "reset_fire");
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 1, 0, 0, "issue_w5");
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "raw5_stall_a");
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "raw5_stall_b");
        step(1, 5, 1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 1, 1, 0, "raw5_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "raw5_drained");
        // x0 is never tracked
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, "x0_write");
        step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, "x0_read");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "x0_idle");
        // Saturation on r7
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, 0, 0, "sat_w1");
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, 1, 0, "sat_w2");
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, 2, 0, "sat_w3");
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   1, 0, 3, 0, "sat_w4_stall");
        step(1, 0, 0, 0, 0, 7, 1, 7, 1, 0, 0,   0, 1, 3, 0, "sat_w4_retire");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, "sat_hold3");
        step(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 3, 0, "sat_drain1");
        step(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 2, 0, "sat_drain2");
        step(1, 7, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 1, 1, 0, "sat_drain3_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "sat_empty");
        // Simultaneous issue and retire on r9
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 1, 0, 0, "sim_w9");
        step(1, 0, 0, 0, 0, 9, 1, 9, 1, 0, 0,   0, 1, 1, 0, "sim_inc_dec");
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, "sim_rs2_stall");
        step(1, 0, 0, 9, 1, 0, 0, 9, 1, 0, 0,   0, 1, 1, 0, "sim_rs2_fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "sim_empty");
        // Underflow
        step(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0,   0, 0, 0, 0, "uf_event");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, "uf_sticky");
        // Build five pending writers, then flush
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 1, "fl_w1");
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0,   0, 1, 1, 1, "fl_w2");
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 1, 2, 1, "fl_w3");
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,   0, 1, 3, 1, "fl_w4");
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 1, 4, 1, "fl_w5");
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 5, 1, "fl_pulse");
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, "fl_after");
        step(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 1, 0, 1, "fl_discard_inc");
        step(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, "fl_r6_clear");
        // Rebuild, then asynchronous reset mid-cycle
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 1, "rs_w1");
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0,   0, 1, 1, 1, "rs_w2");
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 1, 2, 1, "rs_w3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, "rs_async");
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, "rs_after");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, "rs_idle");

        for (int i = 0; i < 5 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
